// File: rtl/eee_msg_reader.sv
// Polls an image-processor register port for bounding-box messages, validates
// each 3-word "RBB" message and latches the box coordinates or counts the error.
module eee_msg_reader #(
    parameter int          POLL_INTERVAL = 1024,
    parameter logic [31:0] MSG_ID        = 32'h00524242,
    parameter int          IMAGE_W       = 640
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        bb_valid,
    output logic [10:0] bb_left,
    output logic [10:0] bb_top,
    output logic [10:0] bb_right,
    output logic [10:0] bb_bottom,
    output logic        bb_present,
    output logic [7:0]  err_count
);

    localparam logic [15:0] POLL_LAST = 16'(POLL_INTERVAL - 1);
    localparam logic [11:0] IMG_LIM   = 12'(IMAGE_W);
    localparam logic [31:0] FLUSH_CMD = 32'h00000010;
    localparam logic [2:0]  ADDR_STAT = 3'd0;
    localparam logic [2:0]  ADDR_MSG  = 3'd1;
    localparam logic [7:0]  MSG_WORDS = 8'd3;

    typedef enum logic [2:0] {
        IDLE,
        ST_RD,
        ST_CAP,
        GAP,
        MSG_RD,
        MSG_CAP,
        CHECK,
        FLUSH
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rst_s1;
    logic        rst_sync_n;
    logic [15:0] poll_cnt;
    logic [1:0]  k;
    logic [31:0] hdr;
    logic [10:0] f_left;
    logic [10:0] f_top;
    logic [10:0] f_right;
    logic [10:0] f_bottom;
    logic        msg_ok;
    logic [7:0]  rd_used;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic coord_ok(input logic [10:0] v);
        return {1'b0, v} < IMG_LIM;
    endfunction

    // Assertion is immediate; release is retimed through two flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_s1     <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_s1     <= 1'b1;
            rst_sync_n <= rst_s1;
        end
    end

    assign rd_used = m_readdata[15:8];
    assign msg_ok  = (hdr == MSG_ID) && coord_ok(f_left) && coord_ok(f_top)
                     && coord_ok(f_right) && coord_ok(f_bottom);

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && poll_cnt == POLL_LAST) state_nxt = ST_RD;
            ST_RD:   state_nxt = ST_CAP;
            ST_CAP:  state_nxt = (rd_used >= MSG_WORDS && enable) ? GAP : IDLE;
            GAP:     state_nxt = MSG_RD;
            MSG_RD:  state_nxt = MSG_CAP;
            MSG_CAP: state_nxt = (k == 2'd2) ? CHECK : GAP;
            CHECK: begin
                if (!msg_ok)     state_nxt = FLUSH;
                else if (enable) state_nxt = ST_RD;
                else             state_nxt = IDLE;
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            m_chipselect <= 1'b0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= 3'd0;
            m_writedata  <= 32'd0;
        end else begin
            m_chipselect <= (state_nxt == ST_RD) || (state_nxt == MSG_RD) || (state_nxt == FLUSH);
            m_read       <= (state_nxt == ST_RD) || (state_nxt == MSG_RD);
            m_write      <= (state_nxt == FLUSH);
            m_address    <= (state_nxt == MSG_RD) ? ADDR_MSG : ADDR_STAT;
            m_writedata  <= (state_nxt == FLUSH) ? FLUSH_CMD : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            poll_cnt <= 16'd0;
        end else if (state == IDLE && enable) begin
            poll_cnt <= (poll_cnt == POLL_LAST) ? 16'd0 : poll_cnt + 16'd1;
        end
    end

    // Message word capture: k selects header, left/top or right/bottom.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            k        <= 2'd0;
            hdr      <= 32'd0;
            f_left   <= 11'd0;
            f_top    <= 11'd0;
            f_right  <= 11'd0;
            f_bottom <= 11'd0;
        end else begin
            if (state == ST_CAP) begin
                k <= 2'd0;
            end
            if (state == MSG_CAP) begin
                k <= k + 2'd1;
                case (k)
                    2'd0: hdr <= m_readdata;
                    2'd1: begin
                        f_left <= m_readdata[26:16];
                        f_top  <= m_readdata[10:0];
                    end
                    default: begin
                        f_right  <= m_readdata[26:16];
                        f_bottom <= m_readdata[10:0];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            bb_valid   <= 1'b0;
            bb_left    <= 11'd0;
            bb_top     <= 11'd0;
            bb_right   <= 11'd0;
            bb_bottom  <= 11'd0;
            bb_present <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            bb_valid <= 1'b0;
            if (state == CHECK) begin
                if (msg_ok) begin
                    bb_valid   <= 1'b1;
                    bb_left    <= f_left;
                    bb_top     <= f_top;
                    bb_right   <= f_right;
                    bb_bottom  <= f_bottom;
                    bb_present <= (f_left <= f_right) && (f_top <= f_bottom);
                end else begin
                    err_count <= sat_inc(err_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_eee_msg_reader.sv
// Bench for eee_msg_reader: FIFO slave model plus a scoreboard of expected
// box/reject outcomes popped as the reader produces them.
module tb_eee_msg_reader;

    localparam int          P      = 16;
    localparam logic [31:0] MSG_ID = 32'h00524242;
    localparam logic [31:0] BAD_ID = 32'h00414141;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        m_chipselect;
    logic        m_read;
    logic        m_write;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = 32'h0;
    logic        bb_valid;
    logic [10:0] bb_left, bb_top, bb_right, bb_bottom;
    logic        bb_present;
    logic [7:0]  err_count;

    typedef struct packed {
        logic        is_err;
        logic [10:0] l, t, r, b;
        logic        pres;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] fifo[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          st_count = 0, st_last = 0, st_prev = 0;
    int          rd1_count = 0;
    int          bbv_last = 0, bbv_prev = 0;
    logic        prev_read = 1'b0;
    logic [7:0]  exp_err = 8'd0;
    exp_t        last_box = '0;
    exp_t        mon_e;

    eee_msg_reader #(.POLL_INTERVAL(P), .MSG_ID(MSG_ID), .IMAGE_W(640)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
        .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .bb_valid(bb_valid), .bb_left(bb_left), .bb_top(bb_top),
        .bb_right(bb_right), .bb_bottom(bb_bottom), .bb_present(bb_present),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Slave: registered read data one cycle after the strobe; flush command empties the FIFO.
    always @(posedge clk) begin
        if (m_chipselect && m_read) begin
            if (m_address == 3'd0)      m_readdata <= {16'h0, 8'(fifo.size()), 8'h0};
            else if (fifo.size() != 0)  m_readdata <= fifo.pop_front();
            else                        m_readdata <= 32'h0;
        end
        if (m_chipselect && m_write && m_address == 3'd0 && m_writedata == 32'h10)
            fifo.delete();
    end

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            prev_read = 1'b0;
            exp_err   = 8'd0;
            last_box  = '0;
        end else begin
            if (m_read) begin
                chk("rd_gap", prev_read, 0);
                chk("rw_excl", m_write, 0);
                if (m_address == 3'd0) begin
                    st_prev = st_last;
                    st_last = cyc;
                    st_count++;
                end else begin
                    rd1_count++;
                end
            end
            prev_read = m_read;
            if (bb_valid) begin
                chk("sb_pending", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("acc_kind", mon_e.is_err, 0);
                    chk("bb_left", bb_left, mon_e.l);
                    chk("bb_top", bb_top, mon_e.t);
                    chk("bb_right", bb_right, mon_e.r);
                    chk("bb_bottom", bb_bottom, mon_e.b);
                    chk("bb_present", bb_present, mon_e.pres);
                    last_box = mon_e;
                    bbv_prev = bbv_last;
                    bbv_last = cyc;
                end
            end
            if (m_write) begin
                chk("wr_addr", m_address, 0);
                chk("wr_data", m_writedata, 32'h10);
                chk("sb_pending", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("rej_kind", mon_e.is_err, 1);
                end
                if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                chk("err_count", err_count, exp_err);
                chk("rej_hold_left", bb_left, last_box.l);
                chk("rej_hold_bottom", bb_bottom, last_box.b);
                chk("rej_hold_pres", bb_present, last_box.pres);
            end
        end
    end

    task automatic expect_msg(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        exp_t e;
        e.l = w1[26:16];
        e.t = w1[10:0];
        e.r = w2[26:16];
        e.b = w2[10:0];
        e.is_err = !((w0 == MSG_ID) && e.l < 11'd640 && e.t < 11'd640
                     && e.r < 11'd640 && e.b < 11'd640);
        e.pres = (e.l <= e.r) && (e.t <= e.b);
        sb.push_back(e);
    endtask

    task automatic send_msg(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        fifo.push_back(w0);
        fifo.push_back(w1);
        fifo.push_back(w2);
        expect_msg(w0, w1, w2);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    function automatic logic [31:0] xy(input int a, input int b);
        return {5'h0, 11'(a), 5'h0, 11'(b)};
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, rel;
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs", m_chipselect, 0);
        chk("rst_rd", m_read, 0);
        chk("rst_wr", m_write, 0);
        chk("rst_addr", m_address, 0);
        chk("rst_wdata", m_writedata, 0);
        chk("rst_valid", bb_valid, 0);
        chk("rst_left", bb_left, 0);
        chk("rst_top", bb_top, 0);
        chk("rst_right", bb_right, 0);
        chk("rst_bottom", bb_bottom, 0);
        chk("rst_pres", bb_present, 0);
        chk("rst_err", err_count, 0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Basic accepted message.
        send_msg(MSG_ID, 32'h0064_0032, 32'h00C8_0096);
        wait_drain(200);
        repeat (5) @(negedge clk);
        chk("hold_left", bb_left, 100);
        chk("hold_pres", bb_present, 1);

        // Only two words buffered: no message read, regular poll spacing.
        s0 = st_count;
        r0 = rd1_count;
        fifo.push_back(MSG_ID);
        fifo.push_back(32'h0064_0032);
        for (int i = 0; i < 200 && st_count < s0 + 3; i++) @(negedge clk);
        chk("poll_seen", st_count >= s0 + 3, 1);
        chk("poll_gap", st_last - st_prev, P + 2);
        chk("no_msg_rd", rd1_count, r0);
        fifo.delete();

        // Bad header: reject and flush.
        send_msg(BAD_ID, 32'h0064_0032, 32'h00C8_0096);
        wait_drain(200);
        chk("flushed", fifo.size(), 0);

        // Two messages back to back, second one an empty box.
        r0 = rd1_count;
        send_msg(MSG_ID, xy(300, 200), xy(400, 250));
        send_msg(MSG_ID, xy(639, 479), xy(0, 0));
        wait_drain(400);
        chk("b2b_gap", bbv_last - bbv_prev, 12);
        chk("b2b_reads", rd1_count - r0, 6);

        // Coordinate boundaries and ignored high bits.
        send_msg(MSG_ID, xy(640, 0), xy(10, 10));
        wait_drain(200);
        send_msg(MSG_ID, 32'hFFFF_F9DF, 32'hF9DF_F9DF);
        wait_drain(200);
        send_msg(MSG_ID, xy(5, 5), xy(6, 640));
        wait_drain(200);

        // enable drops mid-message: message completes, then polling stops.
        r0 = rd1_count;
        send_msg(MSG_ID, xy(10, 20), xy(30, 40));
        for (int i = 0; i < 200 && rd1_count == r0; i++) @(negedge clk);
        enable = 1'b0;
        wait_drain(200);
        s0 = st_count;
        repeat (3 * P) @(negedge clk);
        chk("parked", st_count, s0);
        enable = 1'b1;

        // Reset in MSG_CAP with k=1; leftover word forces one reject afterwards.
        r0 = rd1_count;
        fifo.push_back(MSG_ID);
        fifo.push_back(xy(1, 2));
        fifo.push_back(xy(3, 4));
        for (int i = 0; i < 200 && rd1_count < r0 + 2; i++) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_cs", m_chipselect, 0);
        chk("arst_rd", m_read, 0);
        chk("arst_left", bb_left, 0);
        chk("arst_bottom", bb_bottom, 0);
        chk("arst_pres", bb_present, 0);
        chk("arst_err", err_count, 0);
        chk("arst_fifo", fifo.size(), 1);
        repeat (2) @(negedge clk);
        s0 = st_count;
        rel = cyc;
        reset_n = 1'b1;
        for (int i = 0; i < 4 * P && st_count == s0; i++) @(negedge clk);
        chk("poll_after_rst", (st_last - rel >= P) && (st_last - rel <= P + 4), 1);
        fifo.push_back(MSG_ID);
        fifo.push_back(xy(7, 8));
        fifo.push_back(xy(9, 10));
        expect_msg(xy(3, 4), MSG_ID, xy(7, 8));
        wait_drain(200);
        chk("resync_flush", fifo.size(), 0);
        send_msg(MSG_ID, xy(11, 12), xy(13, 14));
        wait_drain(200);

        // Saturation of the error counter.
        for (int n = 0; n < 256; n++) begin
            send_msg(BAD_ID, xy(1, 1), xy(2, 2));
            wait_drain(200);
        end
        chk("err_sat", err_count, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eee_msg_reader.md
EEE_MSG_READER -- requirements
Module: EEE_MSG_READER

Interface
REQ-001 Parameter POLL_INTERVAL, default 1024: clk cycles from the end of one status poll to the start of the next.
REQ-002 Parameter MSG_ID, default 32'h00524242: the "RBB" message header word.
REQ-003 Parameter IMAGE_W, default 640: a coordinate is legal when it is below this value.
REQ-004 clk  in  1  the single clock; every flop uses it.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  polling is allowed while this is 1.
REQ-007 m_chipselect  out  1  master chip select to the image-processor register port.
REQ-008 m_read  out  1  read strobe.
REQ-009 m_write  out  1  write strobe.
REQ-010 m_address  out  3  register address: 0 = status, 1 = message.
REQ-011 m_writedata  out  32  write data.
REQ-012 m_readdata  in  32  read data, registered by the slave and valid exactly 1 cycle after the strobe.
REQ-013 bb_valid  out  1  one-cycle pulse marking a new box.
REQ-014 bb_left, bb_top, bb_right, bb_bottom  out  11 each  latched box coordinates.
REQ-015 bb_present  out  1  1 when the latched box is non-empty (left<=right and top<=bottom).
REQ-016 err_count  out  8  count of bad messages; saturates at 255.

Function
REQ-017 Reads: one-cycle pulse of m_chipselect=1, m_read=1; m_readdata is captured on the following cycle.
REQ-018 m_read stays low for at least 1 cycle between any two reads, so the slave sees a fresh read edge and pops exactly one word per message read.
REQ-019 m_write is a one-cycle pulse; m_read and m_write are never high together.
REQ-020 FSM states: IDLE, ST_RD, ST_CAP, GAP, MSG_RD, MSG_CAP, CHECK, FLUSH.
REQ-021 IDLE: a 16-bit poll counter counts up while enable=1; at POLL_INTERVAL-1 it clears and the FSM goes to ST_RD.
REQ-022 ST_RD issues a read of address 0; ST_CAP captures used = m_readdata[15:8].
REQ-023 Poll decision: used>=3 -> GAP, with word index k=0; used<3 -> IDLE.
REQ-024 Message loop: GAP -> MSG_RD (read address 1) -> MSG_CAP (store word k) -> k=k+1; k<3 returns to GAP, k=3 goes to CHECK.
REQ-025 CHECK accepts the message when word0==MSG_ID and all four 11-bit fields are below IMAGE_W.
REQ-026 Field mapping: word1[26:16]=left, word1[10:0]=top, word2[26:16]=right, word2[10:0]=bottom.
REQ-027 Accept: bb_* latch the fields, bb_present updates, bb_valid pulses the next cycle, FSM returns to ST_RD to drain any further messages.
REQ-028 Reject: err_count increments (saturating at 255); FSM goes to FLUSH.
REQ-029 FLUSH writes address 0 with data 32'h00000010 (buffer flush), then goes to IDLE to re-synchronise.
REQ-030 enable falling mid-transaction: the current 3-word message completes; the FSM then parks in IDLE.
REQ-031 An empty box (left=639, right=0, top=479, bottom=0) is accepted: bb_valid pulses and bb_present=0.
REQ-032 Coordinates hold their value between accepted messages.

Reset
REQ-033 While reset_n=0: FSM=IDLE; poll counter, k, word registers, all m_* outputs, bb_valid, bb_* and bb_present are 0; err_count=0.
REQ-034 Reset asserted mid-message: the slave keeps its partial FIFO contents; after reset the first reject flushes it.
REQ-035 Outputs change only on clk after reset_n deasserts; the deassertion is synchronised internally with a 2-flop chain.

Verification
REQ-036 Slave model returns used=3, then words 00524242, 0064_0032, 00C8_0096 -> bb_valid pulses once; left=100, top=50, right=200, bottom=150, bb_present=1.
REQ-037 Status reports used=2 -> no address-1 read occurs; next poll comes POLL_INTERVAL cycles later.
REQ-038 Header word 00414141 -> err_count=1, one write of 00000010 to address 0, bb_* unchanged.
REQ-039 used=6 -> two back-to-back messages are decoded with no intervening IDLE; m_read is never high on consecutive cycles.
REQ-040 Assert reset_n low in MSG_CAP with k=1 -> all outputs 0 immediately (asynchronously); polling resumes POLL_INTERVAL cycles after release.
REQ-041 255 bad messages followed by one more -> err_count stays at 255.
